// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the byte-wide data memory sequencer.
//   size_e      - access size encoding as presented on req_size
//   seq_state_e - sequencer FSM states
//   size_bytes  - number of memory byte cycles for an access size
package dmem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01,
    DONE = 2'b10
  } seq_state_e;

  // The reserved size reports 4 so the range arithmetic stays well defined;
  // such a request is rejected regardless of the byte count.
  function automatic logic [2:0] size_bytes(size_e s);
    case (s)
      BYTE:    size_bytes = 3'd1;
      HALF:    size_bytes = 3'd2;
      WORD:    size_bytes = 3'd4;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_seq.sv
// dmem_byte_seq: splits one byte/half/word load or store into little-endian
// single-byte cycles on a byte-wide memory, reassembles and extends loads,
// and rejects out-of-range or reserved-size requests without touching memory.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake (accepted when both high)
//   req_we, req_size,          store flag, size (00 B, 01 H, 10 W, 11 rsvd),
//   req_unsigned               zero-extend loads
//   req_addr, req_wdata        start byte address (any alignment), store data
//   rsp_valid                  one-cycle completion pulse
//   rsp_err, rsp_rdata         error flag and extended load data (0 otherwise)
//   mem_we, mem_a, mem_wd      memory write enable, address, write data
//   mem_rd                     memory combinational read data
module dmem_byte_seq
  import dmem_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] MEM_TOP       = 'h1FFFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     rsp_valid,
  output logic                     rsp_err,
  output logic [31:0]              rsp_rdata,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [7:0]               mem_wd,
  input  logic [7:0]               mem_rd
);

  localparam int AW1 = ADDRESS_WIDTH + 1;

  seq_state_e               state_q, state_d;
  logic                     we_q, we_d;
  size_e                    size_q, size_d;
  logic                     uns_q, uns_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [31:0]              rdata_q, rdata_d;
  logic [1:0]               idx_q, idx_d;
  logic                     err_q, err_d;

  logic [2:0]               req_n;
  logic [AW1-1:0]           req_last;
  logic                     req_err;
  logic [1:0]               last_idx;
  logic [31:0]              load_ext;

  // Range check of the incoming request. The extra top bit keeps an access
  // that wraps past the end of the address space from looking in range.
  always_comb begin
    req_n    = size_bytes(size_e'(req_size));
    req_last = {1'b0, req_addr} + AW1'(req_n) - AW1'(1);
    req_err  = (req_last > {1'b0, MEM_TOP}) || (size_e'(req_size) == RSVD);
    last_idx = 2'(size_bytes(size_q) - 3'd1);
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: latch the request in IDLE, walk one byte per cycle in
  // XFER capturing load bytes into their lanes, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = size_e'(req_size);
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          idx_d   = '0;
          err_d   = req_err;
          state_d = req_err ? DONE : XFER;
        end
      end
      XFER: begin
        if (!we_q) begin
          rdata_d[{idx_q, 3'b000} +: 8] = mem_rd;
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == last_idx) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Load extension from the captured lanes; words pass straight through.
  always_comb begin
    case (size_q)
      BYTE:    load_ext = uns_q ? {24'h0, rdata_q[7:0]}
                                : {{24{rdata_q[7]}}, rdata_q[7:0]};
      HALF:    load_ext = uns_q ? {16'h0, rdata_q[15:0]}
                                : {{16{rdata_q[15]}}, rdata_q[15:0]};
      default: load_ext = rdata_q;
    endcase
  end

  // Outputs decode registered state only, so nothing on req_* or mem_rd
  // reaches an output combinationally.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == DONE);
    rsp_err   = (state_q == DONE) && err_q;
    rsp_rdata = ((state_q == DONE) && !err_q && !we_q) ? load_ext : 32'h0;
    mem_we    = (state_q == XFER) && we_q;
    mem_a     = (state_q == XFER) ? addr_q + ADDRESS_WIDTH'(idx_q) : '0;
    mem_wd    = (state_q == XFER) ? wdata_q[{idx_q, 3'b000} +: 8] : 8'h00;
  end

endmodule

// File: doc/dmem_byte_seq.md
# dmem_byte_seq

Access sequencer between the pipeline's load/store stage and the byte-wide data memory (8-bit data, 32-bit byte address, write on clock edge, combinational read). It accepts one byte, halfword or word load/store per valid/ready handshake and splits it into little-endian single-byte memory cycles. Loads are reassembled and sign- or zero-extended. Requests that fall outside the implemented memory range complete with an error and no memory write.

## Interface
Parameters:
- `ADDRESS_WIDTH`, default 32: byte address width.
- `MEM_TOP`, default 32'h1FFFF: highest valid byte address. Valid range is 0..`MEM_TOP`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned`  in  1  load zero-extend (LBU/LHU).
- `req_addr`  in  ADDRESS_WIDTH  start byte address. No alignment required.
- `req_wdata`  in  32  store data. Low bytes are used.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_err`  out  1  qualified by `rsp_valid`. Out of range or reserved size.
- `rsp_rdata`  out  32  qualified by `rsp_valid`. Extended load data; 0 for stores and errors.
- `mem_we`  out  1  to the memory's write-enable.
- `mem_a`  out  ADDRESS_WIDTH  to the memory's address input.
- `mem_wd`  out  8  to the memory's write-data input.
- `mem_rd`  in  8  from the memory's read-data output (combinational).

## Operation
- Byte count n: 1, 2 or 4 for `req_size` 00, 01, 10.
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch we, size, unsigned, addr and wdata; clear byte index `idx`.
  - Range check is done in ADDRESS_WIDTH+1 bits: error if `addr + n - 1 > MEM_TOP`, or size = 11. This also catches 32-bit wrap, e.g. 0xFFFFFFFF word.
  - Error: go to DONE with the error flag set. Otherwise go to XFER.
- XFER, one byte per cycle:
  - `mem_a` = addr + idx.
  - `mem_we` = we.
  - `mem_wd` = wdata[8*idx +: 8].
  - On load, capture `mem_rd` into byte lane idx at the clock edge.
  - `idx` increments each cycle. When idx = n-1, go to DONE.
- DONE:
  - `rsp_valid` = 1 for exactly one cycle; `rsp_err` = error flag.
  - `rsp_rdata` for a load: byte/half are sign-extended from bit 7/15, or zero-extended if unsigned; word passes through.
  - Return to IDLE.
- Outside XFER: `mem_we` = 0, `mem_a` = 0, `mem_wd` = 0.
- `req_ready` = 0 in XFER and DONE. `req_valid` asserted then is ignored, not queued.
- Reset (any state, mid-access included):
  - Go to IDLE.
  - `req_ready` = 1; `rsp_valid`, `rsp_err`, `mem_we` = 0; `rsp_rdata`, `mem_a`, `mem_wd` = 0.
  - Bytes already written stay in memory. There is no rollback and no response for the aborted access.

## Timing
- Request accepted at edge T.
- Memory cycles occur at T+1..T+n. Each store byte commits at the end of its cycle.
- `rsp_valid` is high in cycle T+n+1.
- `req_ready` is high again in cycle T+n+2.
- Throughput: n+2 cycles per access.
- Error path: `rsp_valid` in T+1, no memory cycles.
- All outputs are registered or decoded from registered state only. No combinational path from `req_*` or `mem_rd` to any output.

## Structure
- Shared package `dmem_pkg`:
  - `size_e` enum (BYTE, HALF, WORD, RSVD).
  - `seq_state_e` (IDLE, XFER, DONE).
  - Function `size_bytes(size_e)`.
- Single module. Load extension is a small always_comb inside it. No sub-module.

## Test plan
- Store word 0xDEADBEEF at 0x10000, accepted at T:
  - Memory 0x10000..0x10003 = EF, BE, AD, DE.
  - `mem_we` high T+1..T+4.
  - `rsp_valid` at T+5, err 0, rdata 0.
- After the store above:
  - LB 0x10003 → 0xFFFFFFDE.
  - LBU 0x10003 → 0x000000DE.
  - LHU 0x10002 → 0x0000DEAD.
  - LH 0x10000 → 0xFFFFBEEF.
- Misaligned LW 0x10001, with 0x10004 = 0x11 → rdata 0x11DEADBE, response at T+5.
- Out of range:
  - SW 0x1FFFE → `rsp_valid` + err at T+1, `mem_we` never high, rdata 0.
  - LW 0xFFFFFFFF → err.
  - LB 0x1FFFF → ok, no err.
- `req_valid` held continuously across two SH requests → second is accepted only in the cycle `req_ready` returns (T+4). Spacing is exactly 4 cycles.
- `rst_n` low during XFER of SW 0x10010 (data 0x44332211) after 2 bytes:
  - 0x10010 = 11, 0x10011 = 22.
  - 0x10012 and 0x10013 unchanged.
  - All outputs at reset values while `rst_n` is low.
  - No `rsp_valid` after release; next request serviced normally.
